// File: rtl/retro_memory_target_if.sv
// ---------------------------------------------------------------------------
// retro_memory_target_if
//
// Memory port bundle shared by an initiator and a memory target.
//   Address      word address                  (initiator -> target)
//   DToTarget    write data, 8*DataBusWidth    (initiator -> target)
//   Access       command request               (initiator -> target)
//   Mask         per-byte write enables        (initiator -> target)
//   Write        1 = write, 0 = read           (initiator -> target)
//   DToInitiator read data                     (target -> initiator)
//   Ready        command accepted this cycle   (target -> initiator)
//   DataReady    DToInitiator valid this cycle (target -> initiator)
//
// Modports: master (initiator side), slave (target side).
// ---------------------------------------------------------------------------
interface retro_memory_target_if #(
  parameter int AddressBusWidth = 16,
  parameter int DataBusWidth    = 1
);
  logic [AddressBusWidth-1:0]  Address;
  logic [8*DataBusWidth-1:0]   DToTarget;
  logic                        Access;
  logic [DataBusWidth-1:0]     Mask;
  logic                        Write;
  logic [8*DataBusWidth-1:0]   DToInitiator;
  logic                        Ready;
  logic                        DataReady;

  modport master (
    output Address, DToTarget, Access, Mask, Write,
    input  DToInitiator, Ready, DataReady
  );

  modport slave (
    input  Address, DToTarget, Access, Mask, Write,
    output DToInitiator, Ready, DataReady
  );
endinterface

// File: rtl/retro_memory_target.sv
// ---------------------------------------------------------------------------
// retro_memory_target
//
// RAM endpoint for the memory port. Writes are byte-masked and take effect at
// the accept edge. Reads return ReadLatency edges after acceptance, one
// DataReady pulse each, in issue order. With StallPeriod != 0 the target
// periodically drops Ready for StallCycles cycles; reads already in flight
// keep moving through the pipeline during a stall.
//
// Ports:
//   Clk     rising-edge clock
//   nReset  asynchronous active-low reset (array contents are kept)
//   bus     retro_memory_target_if slave modport (see interface header)
// ---------------------------------------------------------------------------
module retro_memory_target #(
  parameter int AddressBusWidth = 16,
  parameter int DataBusWidth    = 1,
  parameter int ReadLatency     = 2,   // 1..8
  parameter int StallPeriod     = 0,   // 0 disables stalls
  parameter int StallCycles     = 2    // >= 1 when StallPeriod != 0
) (
  input logic                  Clk,
  input logic                  nReset,
  retro_memory_target_if.slave bus
);

  localparam int Depth   = 2 ** AddressBusWidth;
  localparam int WordW   = 8 * DataBusWidth;
  localparam int PeriodW = (StallPeriod > 1) ? $clog2(StallPeriod) : 1;
  localparam int StallW  = (StallCycles > 1) ? $clog2(StallCycles) : 1;

  typedef enum logic [1:0] {INIT, RUN, STALL} state_e;

  state_e               state_q, state_d;
  logic [PeriodW-1:0]   period_cnt_q, period_cnt_d;
  logic [StallW-1:0]    stall_cnt_q, stall_cnt_d;
  logic                 ready_q, ready_d;

  logic [ReadLatency-1:0] vld_q, vld_d;
  logic [WordW-1:0]       data_q [ReadLatency];
  logic [WordW-1:0]       data_d [ReadLatency];
  logic                   data_ready_q, data_ready_d;
  logic [WordW-1:0]       dout_q, dout_d;

  logic [WordW-1:0] mem_q [Depth];
  logic [WordW-1:0] rd_word;
  logic             accept_rd, accept_wr;

  // Ready is the registered flag the initiator saw, so acceptance uses it.
  assign accept_rd = bus.Access && ready_q && !bus.Write;
  assign accept_wr = bus.Access && ready_q &&  bus.Write;

  // A write accepted on an earlier edge is already in the array, so a read on
  // the following edge sees the merged word without any bypass path.
  assign rd_word = mem_q[bus.Address];

  // ---------------- control FSM ----------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    unique case (state_q)
      INIT: state_d = RUN;
      RUN: begin
        if (StallPeriod != 0) begin
          if (period_cnt_q == PeriodW'(StallPeriod - 1)) begin
            state_d      = STALL;
            period_cnt_d = '0;
          end else begin
            period_cnt_d = period_cnt_q + PeriodW'(1);
          end
        end
      end
      STALL: begin
        if (stall_cnt_q == StallW'(StallCycles - 1)) begin
          state_d     = RUN;
          stall_cnt_d = '0;
        end else begin
          stall_cnt_d = stall_cnt_q + StallW'(1);
        end
      end
      default: state_d = INIT;
    endcase
    // Ready is registered, so it follows the state being entered.
    ready_d = (state_d == RUN);
  end

  // ---------------- read pipeline ----------------
  always_comb begin
    vld_d[0]  = accept_rd;
    data_d[0] = rd_word;
    for (int k = 1; k < ReadLatency; k++) begin
      vld_d[k]  = vld_q[k-1];
      data_d[k] = data_q[k-1];
    end
    // Output register adds the final edge and holds the last read value.
    data_ready_d = vld_q[ReadLatency-1];
    dout_d       = vld_q[ReadLatency-1] ? data_q[ReadLatency-1] : dout_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q      <= INIT;
      period_cnt_q <= '0;
      stall_cnt_q  <= '0;
      ready_q      <= 1'b0;
      vld_q        <= '0;
      for (int k = 0; k < ReadLatency; k++) data_q[k] <= '0;
      data_ready_q <= 1'b0;
      dout_q       <= '0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      ready_q      <= ready_d;
      vld_q        <= vld_d;
      for (int k = 0; k < ReadLatency; k++) data_q[k] <= data_d[k];
      data_ready_q <= data_ready_d;
      dout_q       <= dout_d;
    end
  end

  // NOTE: the array has no reset; clearing it would prevent RAM inference and
  // written data must survive nReset anyway.
  always_ff @(posedge Clk) begin
    if (accept_wr) begin
      for (int i = 0; i < DataBusWidth; i++) begin
        if (bus.Mask[i]) mem_q[bus.Address][8*i +: 8] <= bus.DToTarget[8*i +: 8];
      end
    end
  end

  assign bus.Ready        = ready_q;
  assign bus.DataReady    = data_ready_q;
  assign bus.DToInitiator = dout_q;

endmodule

// File: tb/tb_retro_memory_target.sv
// ---------------------------------------------------------------------------
// tb_retro_memory_target
//
// Two targets share clock and reset: u_main (2-byte words, latency 2, no
// stalls) runs a vector table plus reset sequences; u_stall (1-byte words,
// latency 2, stall period 8 / 3 cycles) runs held-command streams against a
// small queue model. Outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_retro_memory_target;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  retro_memory_target_if #(.AddressBusWidth(16), .DataBusWidth(2)) m_if ();
  retro_memory_target_if #(.AddressBusWidth(16), .DataBusWidth(1)) s_if ();

  retro_memory_target #(
    .AddressBusWidth(16), .DataBusWidth(2), .ReadLatency(2),
    .StallPeriod(0), .StallCycles(2)
  ) u_main (.Clk(clk), .nReset(rst_n), .bus(m_if));

  retro_memory_target #(
    .AddressBusWidth(16), .DataBusWidth(1), .ReadLatency(2),
    .StallPeriod(8), .StallCycles(3)
  ) u_stall (.Clk(clk), .nReset(rst_n), .bus(s_if));

  int total = 0;
  int bad   = 0;

  // Rising edges since the last reset release.
  int edges;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        acc;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  mask;
    logic        exp_dr;
    logic [15:0] exp_dout;
  } vec_t;

  localparam int NVec = 42;
  vec_t vecs [NVec];

  function automatic vec_t mk(input logic acc, input logic wr, input logic [15:0] addr,
                              input logic [15:0] data, input logic [1:0] mask,
                              input logic exp_dr, input logic [15:0] exp_dout);
    vec_t v;
    v.acc = acc; v.wr = wr; v.addr = addr; v.data = data; v.mask = mask;
    v.exp_dr = exp_dr; v.exp_dout = exp_dout;
    return v;
  endfunction

  task automatic m_drive(input logic acc, input logic wr, input logic [15:0] addr,
                         input logic [15:0] data, input logic [1:0] mask);
    m_if.Access = acc; m_if.Write = wr; m_if.Address = addr;
    m_if.DToTarget = data; m_if.Mask = mask;
  endtask

  // Single read on u_main: DataReady must be low one edge after accept and
  // high with the expected word exactly two edges after.
  task automatic main_read(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    m_drive(1'b1, 1'b0, addr, 16'h0, 2'b00);
    @(posedge clk); #1;
    m_drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    @(posedge clk); #1;
    check({tag, " dr@1"}, m_if.DataReady, 1'b0);
    @(posedge clk); #1;
    check({tag, " dr@2"}, m_if.DataReady, 1'b1);
    check({tag, " data"}, m_if.DToInitiator, exp);
  endtask

  // Stream n held commands to u_stall (addr i, data 0x10+i). Reads are
  // tracked in a queue of accept edges; DataReady is predicted every cycle.
  task automatic stall_run(input string tag, input logic wr, input int n);
    int          issued;
    logic        acc;
    logic        exp_dr;
    logic        exp_rdy;
    logic [7:0]  dat_q [$];
    int          cyc_q [$];
    issued = 0;
    s_if.Write = wr; s_if.Mask = 1'b1; s_if.Access = 1'b1;
    s_if.Address = 16'h0; s_if.DToTarget = 8'h10;
    for (int c = 0; c < 60 && (issued < n || cyc_q.size() > 0); c++) begin
      acc = s_if.Access && s_if.Ready;
      @(posedge clk); #1;
      if (acc) begin
        if (!wr) begin
          dat_q.push_back(8'(16 + issued));
          cyc_q.push_back(edges);
        end
        issued++;
      end
      exp_rdy = ((edges - 1) % 11) < 8;
      check($sformatf("%s ready e%0d", tag, edges), s_if.Ready, exp_rdy);
      exp_dr = (cyc_q.size() > 0) && (cyc_q[0] + 2 == edges);
      check($sformatf("%s dr e%0d", tag, edges), s_if.DataReady, exp_dr);
      if (exp_dr) begin
        check($sformatf("%s data e%0d", tag, edges), s_if.DToInitiator, dat_q[0]);
        void'(dat_q.pop_front());
        void'(cyc_q.pop_front());
      end
      s_if.Access    = (issued < n);
      s_if.Address   = 16'(issued);
      s_if.DToTarget = 8'(16 + issued);
    end
    s_if.Access = 1'b0;
    check({tag, " issued"}, issued, n);
    check({tag, " outstanding"}, cyc_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dr_cnt;
    m_drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    s_if.Access = 1'b0; s_if.Write = 1'b0; s_if.Address = '0;
    s_if.DToTarget = '0; s_if.Mask = '0;

    // Vector table for u_main (expectations after each edge).
    vecs[0]  = mk(1, 1, 16'h0010, 16'h00A5, 2'b11, 0, 16'h0000);
    vecs[1]  = mk(1, 0, 16'h0010, 16'h0000, 2'b00, 0, 16'h0000);
    vecs[2]  = mk(0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000);
    vecs[3]  = mk(0, 0, 16'h0000, 16'h0000, 2'b00, 1, 16'h00A5);
    vecs[4]  = mk(0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h00A5);
    vecs[5]  = mk(1, 1, 16'h0020, 16'h1234, 2'b11, 0, 16'h00A5);
    vecs[6]  = mk(1, 1, 16'h0020, 16'hABCD, 2'b01, 0, 16'h00A5);
    vecs[7]  = mk(1, 0, 16'h0020, 16'h0000, 2'b00, 0, 16'h00A5);
    vecs[8]  = mk(0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h00A5);
    vecs[9]  = mk(0, 0, 16'h0000, 16'h0000, 2'b00, 1, 16'h12CD);
    vecs[10] = mk(1, 1, 16'h0001, 16'h0011, 2'b11, 0, 16'h12CD);
    vecs[11] = mk(1, 1, 16'h0002, 16'h0022, 2'b11, 0, 16'h12CD);
    vecs[12] = mk(1, 1, 16'h0003, 16'h0033, 2'b11, 0, 16'h12CD);
    vecs[13] = mk(1, 1, 16'h0004, 16'h0044, 2'b11, 0, 16'h12CD);
    vecs[14] = mk(1, 0, 16'h0001, 16'h0000, 2'b00, 0, 16'h12CD);
    vecs[15] = mk(1, 0, 16'h0002, 16'h0000, 2'b00, 0, 16'h12CD);
    vecs[16] = mk(1, 0, 16'h0003, 16'h0000, 2'b00, 1, 16'h0011);
    vecs[17] = mk(1, 0, 16'h0004, 16'h0000, 2'b00, 1, 16'h0022);
    vecs[18] = mk(0, 0, 16'h0000, 16'h0000, 2'b00, 1, 16'h0033);
    vecs[19] = mk(0, 0, 16'h0000, 16'h0000, 2'b00, 1, 16'h0044);
    vecs[20] = mk(0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0044);
    vecs[21] = mk(1, 1, 16'h0007, 16'h0077, 2'b11, 0, 16'h0044);
    vecs[22] = mk(1, 1, 16'h0007, 16'h005A, 2'b11, 0, 16'h0044);
    vecs[23] = mk(1, 0, 16'h0007, 16'h0000, 2'b00, 0, 16'h0044);
    vecs[24] = mk(0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0044);
    vecs[25] = mk(0, 0, 16'h0000, 16'h0000, 2'b00, 1, 16'h005A);
    vecs[26] = mk(1, 1, 16'h0007, 16'hFFFF, 2'b00, 0, 16'h005A);
    vecs[27] = mk(1, 0, 16'h0007, 16'h0000, 2'b00, 0, 16'h005A);
    vecs[28] = mk(0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h005A);
    vecs[29] = mk(0, 0, 16'h0000, 16'h0000, 2'b00, 1, 16'h005A);
    vecs[30] = mk(1, 1, 16'h0007, 16'hBEEF, 2'b10, 0, 16'h005A);
    vecs[31] = mk(1, 0, 16'h0007, 16'h0000, 2'b00, 0, 16'h005A);
    vecs[32] = mk(0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h005A);
    vecs[33] = mk(0, 0, 16'h0000, 16'h0000, 2'b00, 1, 16'hBE5A);
    vecs[34] = mk(0, 1, 16'h0007, 16'h0000, 2'b11, 0, 16'hBE5A);
    vecs[35] = mk(1, 0, 16'h0007, 16'h0000, 2'b00, 0, 16'hBE5A);
    vecs[36] = mk(0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'hBE5A);
    vecs[37] = mk(0, 0, 16'h0000, 16'h0000, 2'b00, 1, 16'hBE5A);
    vecs[38] = mk(1, 1, 16'hFFFF, 16'hC3C3, 2'b11, 0, 16'hBE5A);
    vecs[39] = mk(1, 0, 16'hFFFF, 16'h0000, 2'b00, 0, 16'hBE5A);
    vecs[40] = mk(0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'hBE5A);
    vecs[41] = mk(0, 0, 16'h0000, 16'h0000, 2'b00, 1, 16'hC3C3);

    // Reset state and release timing.
    repeat (3) @(posedge clk);
    #1;
    check("rst ready", m_if.Ready, 1'b0);
    check("rst dr", m_if.DataReady, 1'b0);
    check("rst dout", m_if.DToInitiator, 16'h0000);
    check("rst stall ready", s_if.Ready, 1'b0);
    rst_n = 1'b1;
    #1;
    check("release ready before edge", m_if.Ready, 1'b0);
    @(posedge clk); #1;
    check("ready after first edge", m_if.Ready, 1'b1);
    check("stall ready after first edge", s_if.Ready, 1'b1);

    // Table-driven main function.
    for (int i = 0; i < NVec; i++) begin
      m_drive(vecs[i].acc, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].mask);
      @(posedge clk); #1;
      check($sformatf("vec%0d dr", i), m_if.DataReady, vecs[i].exp_dr);
      check($sformatf("vec%0d dout", i), m_if.DToInitiator, vecs[i].exp_dout);
      check($sformatf("vec%0d ready", i), m_if.Ready, 1'b1);
    end

    // Reset with two reads in flight.
    m_drive(1'b1, 1'b0, 16'h0010, 16'h0, 2'b00);
    @(posedge clk); #1;
    m_drive(1'b1, 1'b0, 16'h0001, 16'h0, 2'b00);
    @(posedge clk); #1;
    m_drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    rst_n = 1'b0;
    #1;
    check("midrst ready", m_if.Ready, 1'b0);
    check("midrst dr", m_if.DataReady, 1'b0);
    check("midrst dout", m_if.DToInitiator, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("midrst release ready", m_if.Ready, 1'b0);
    dr_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (m_if.DataReady) dr_cnt++;
    end
    check("midrst no dataready", dr_cnt, 0);
    check("midrst ready back", m_if.Ready, 1'b1);
    main_read("post-rst 0010", 16'h0010, 16'h00A5);
    main_read("post-rst 0001", 16'h0001, 16'h0011);
    main_read("post-rst 0020", 16'h0020, 16'h12CD);

    // Stalling target: held writes, then held back-to-back reads.
    stall_run("stall wr", 1'b1, 16);
    stall_run("stall rd", 1'b0, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/retro_memory_target.md
Name: retro_memory_target

Overview:
- Target-side responder for the team's memory port interface (Target modport), backed by on-chip block RAM.
- Models a latency-bearing memory behind the port: reads are pipelined with a fixed latency and return in FIFO order with DataReady. Optional periodic refresh-style stalls drop Ready.
- Serves as the standard RAM endpoint for initiators and as a bench model for exercising initiator Ready/DataReady handling.

Parameters:
- AddressBusWidth, 16: address width; array depth is 2**AddressBusWidth words.
- DataBusWidth, 1: word width in bytes.
- ReadLatency, 2: edges from read acceptance to DataReady; legal range 1..8.
- StallPeriod, 0: cycles between stall windows; 0 disables stalls.
- StallCycles, 2: length of each stall window in cycles; must be at least 1 when StallPeriod is non-zero.

Ports:
- Clk  in  1  single clock; all logic on rising edge.
- nReset  in  1  asynchronous, active-low reset.
- Address  in  AddressBusWidth  word address.
- DToTarget  in  8*DataBusWidth  write data.
- Access  in  1  command request.
- Mask  in  DataBusWidth  byte enables; bit=1 writes the byte, bit=0 masks it.
- Write  in  1  1 = write, 0 = read.
- DToInitiator  out  8*DataBusWidth  read data.
- Ready  out  1  command accepted this cycle when high.
- DataReady  out  1  DToInitiator valid this cycle; one pulse per read.

Behaviour:
- One clock (Clk). Reset is asynchronous and active-low (nReset).
- While nReset=0: Ready=0, DataReady=0, DToInitiator=0, state=INIT, stall counter=0, read pipeline cleared.
- Array contents are not cleared by reset.
- State machine:
  - INIT -> RUN on the first edge after nReset deasserts. Ready goes to 1 on that edge.
  - RUN -> STALL on the edge where the period counter reaches StallPeriod-1. The counter increments every RUN cycle and wraps to 0.
  - STALL -> RUN after StallCycles cycles.
  - With StallPeriod=0 the block stays in RUN permanently.
- Ready is registered: 1 in RUN, 0 in INIT and STALL.
- Acceptance: a command is accepted at a rising edge where Access=1 and Ready=1.
  - Access=1 with Ready=0 is ignored with no side effects. The initiator holds the command until it is accepted.
- Write accept:
  - Each byte i with Mask[i]=1 is updated from DToTarget at the accept edge; Mask[i]=0 bytes keep old data.
  - Mask=0 is a legal no-op write.
  - A write produces no DataReady.
- Read accept:
  - DataReady=1 and DToInitiator=data for exactly one cycle, beginning ReadLatency edges after the accept edge.
  - Back-to-back reads (one per cycle) yield DataReady on consecutive cycles in issue order.
- Read-after-write: a read accepted on the edge after a write to the same address returns the new merged data (write-first or forwarding).
- One command per cycle, so no simultaneous read/write hazard exists.
- In-flight reads continue through STALL: entering STALL never drops or delays an accepted read.
- DToInitiator holds the last read value while DataReady=0.
- Address wraps naturally within 2**AddressBusWidth; there is no out-of-range case.
- Reset mid-operation:
  - In-flight reads are discarded, with no DataReady after reset.
  - Writes already accepted remain in the array.
- Latency counting uses a ReadLatency-deep valid shift register alongside the data/read-address pipeline.
- There is no initiator backpressure. DataReady is never held off.

Test Plan:
- Reset, then write addr 0x0010 data 0xA5 Mask=1, then read 0x0010 with ReadLatency=2 -> DataReady exactly 2 edges after read accept, DToInitiator=0xA5.
- DataBusWidth=2: write 0x1234 Mask=11, then write 0xABCD Mask=01, then read -> 0x12CD.
- Reads of addresses 1, 2, 3, 4 on consecutive cycles holding 0x11, 0x22, 0x33, 0x44 -> four consecutive DataReady cycles in order 0x11, 0x22, 0x33, 0x44.
- StallPeriod=8, StallCycles=3, continuous Access reads -> Ready low 3 of every 11 cycles. Reads accepted before a stall still return on time; held commands are accepted when Ready returns; no lost or duplicate DataReady.
- Write 0x5A to addr 7, then read addr 7 on the next edge -> returns 0x5A, not stale data.
- Issue 2 reads, assert nReset low before their return, release -> no DataReady. Ready=0 until the first edge after release. Previously written data is intact on a subsequent read.
